shift_unit_iter: RTL
====================

# shift_unit_iter

Parametrised, multi-cycle successor to the single-bit ALU shift path: shifts or rotates a selected WIDTH-bit operand by a programmable amount. It processes up to STEP bit positions per clock under a start/busy/done handshake, adds arithmetic-right and rotate modes, and flags illegal opcodes. It sits in the ALU next to the arithmetic and logic units and is started by the ALU control through Shift_EN.

## Interface
- WIDTH, 16: operand/result width; power of two, >= 4.
- STEP, 1: bit positions shifted per cycle; 1 <= STEP <= WIDTH.
- AW, $clog2(WIDTH): derived width of the shift amount; not overridden.
- clk  in  1  system clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- Shift_EN  in  1  start request; sampled only when Busy=0.
- Shift_Clr  in  1  synchronous abort; return to IDLE, no flag.
- A, B  in  WIDTH each  operands.
- ALU_FUN  in  4  [3] operand select (0=A, 1=B); [2:0] opcode.
- SHAMT  in  AW  shift amount, 0..WIDTH-1.
- Shift_OUT  out  WIDTH  registered result; holds until the next completion.
- Shift_Flag  out  1  one-cycle completion pulse.
- Shift_Err  out  1  one-cycle pulse with Shift_Flag for an illegal opcode.
- Busy  out  1  operation in progress; high in RUN.

## Operation
- Opcodes:
  - 000 SRL: logical right, zero fill.
  - 001 SLL: logical left, zero fill.
  - 010 SRA: arithmetic right, MSB fill.
  - 011 ROR: rotate right.
  - 100 ROL: rotate left.
  - 101-111: illegal.
- States are IDLE, RUN and DONE.
- IDLE or DONE, with Shift_EN=1 and Shift_Clr=0 at an edge:
  - Capture the operand (A or B per ALU_FUN[3]), the opcode and SHAMT into work registers.
  - Go to RUN when the opcode is legal, else to DONE with the error set.
- RUN, at each edge:
  - Shift the work register by s = min(remaining, STEP) and decrement remaining by s.
  - When remaining reaches 0, load the post-shift value into Shift_OUT and go to DONE.
- SHAMT=0 takes one RUN cycle with s=0, so Shift_OUT equals the operand.
- DONE lasts one cycle: Shift_Flag=1, and Shift_Err=1 when the error is set. Then return to IDLE, or back to RUN if a new start is sampled in DONE.
- Illegal opcode: Shift_OUT is not updated.
- Shift_EN while Busy=1 is ignored; it is neither queued nor an error.
- Shift_Clr:
  - Has priority over Shift_EN.
  - In RUN: go to IDLE, Shift_OUT unchanged, no Shift_Flag.
  - In DONE: the flag pulse already in progress completes.
- All shifts stay within WIDTH bits: bits shifted out are discarded (SRL/SLL/SRA) or wrap around (ROR/ROL).
- Combinational inputs are not required to be stable after the sampling edge.

## Timing
- Reset (RST=1, asynchronous): state=IDLE, Shift_OUT=0, Shift_Flag=0, Shift_Err=0, Busy=0, work registers=0.
- Reset in mid-operation discards the operation with no flag. The first start is accepted at the first rising edge with RST=0.
- Start sampled at edge E0. Busy=1 from E0 until E_L, where L = max(1, ceil(SHAMT/STEP)).
- At E_L:
  - Shift_OUT is updated.
  - Shift_Flag=1 for the cycle between E_L and E_L+1.
  - Busy=0 from E_L.
- Illegal opcode: Busy stays 0; Shift_Flag=Shift_Err=1 from E1 to E2.
- Back-to-back: a start sampled at E_L (while Shift_Flag=1) begins the next operation. Sustained throughput is one result per L+1 cycles.
- Shift_Flag and Shift_Err are never high for more than one consecutive cycle per operation.

## Test plan
- WIDTH=16, STEP=4, A=16'h8001, ALU_FUN=4'b0000, SHAMT=5:
  - Busy high for 2 cycles.
  - At E2: Shift_OUT=16'h0400, Shift_Flag pulse, Shift_Err=0.
- Modes, WIDTH=16, STEP=4:
  - SRA B=16'h8000, SHAMT=15 → 16'hFFFF after 4 cycles.
  - ROL A=16'h8001, SHAMT=4 → 16'h0018 after 1 cycle.
  - ROR A=16'h0001, SHAMT=1 → 16'h8000.
  - SLL A=16'hFFFF, SHAMT=8 → 16'hFF00.
- Boundaries:
  - SHAMT=0, A=16'h1234 → 16'h1234 at E1.
  - STEP=1, SHAMT=15 → Busy for 15 cycles.
  - Opcode 3'b110 → Shift_Flag and Shift_Err at E1, Shift_OUT keeps its prior value.
- Handshake:
  - Shift_EN pulsed in mid-RUN → ignored; result and latency unchanged.
  - New Shift_EN in the Shift_Flag cycle → second result after its own L cycles, no lost flag.
- Abort and reset:
  - Shift_Clr in RUN → IDLE next edge, no Shift_Flag, Shift_OUT unchanged.
  - RST asserted mid-RUN between edges → all outputs 0 immediately; a start after release works normally.

Source files
------------

// File: rtl/shift_unit_iter.sv
// Iterative shifter/rotator: moves a WIDTH-bit operand up to STEP bit positions per clock
// under a start/busy/done handshake, with illegal-opcode reporting.
//
// state  | meaning
// IDLE   | waiting for Shift_EN
// RUN    | shifting the work register, Busy high
// DONE   | completion cycle; an illegal-opcode flag pulse follows on the next cycle
`timescale 1ns/1ps

module shift_unit_iter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             Shift_EN,
    input  logic             Shift_Clr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    input  logic [AW-1:0]    SHAMT,
    output logic [WIDTH-1:0] Shift_OUT,
    output logic             Shift_Flag,
    output logic             Shift_Err,
    output logic             Busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   STEP_W  = (AW+1)'(STEP);
    localparam logic [AW+1:0] WIDTH_W = (AW+2)'(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [WIDTH-1:0] out_q;
    logic [AW-1:0]    rem_q;
    logic [AW:0]      rem_ext;
    logic [AW:0]      s;
    logic [AW:0]      rem_d;
    logic [AW+1:0]    s_inv;
    logic [2:0]       op_q;
    logic             err_q;
    logic             flag_q;
    logic             err_flag_q;
    logic             busy_q;
    logic [WIDTH-1:0] operand;
    logic             legal;
    logic             start_ok;

    assign operand  = ALU_FUN[3] ? B : A;
    assign legal    = (ALU_FUN[2:0] <= 3'd4);
    assign start_ok = Shift_EN && !Shift_Clr && (state_q != S_RUN);

    // One iteration: shift by min(remaining, STEP)
    always_comb begin
        rem_ext = {1'b0, rem_q};
        s       = (rem_ext < STEP_W) ? rem_ext : STEP_W;
        rem_d   = rem_ext - s;
        s_inv   = WIDTH_W - {1'b0, s};
        work_d  = work_q;
        case (op_q)
            3'd0:    work_d = work_q >> s;
            3'd1:    work_d = work_q << s;
            3'd2:    work_d = $unsigned($signed(work_q) >>> s);
            3'd3:    work_d = (work_q >> s) | (work_q << s_inv);
            3'd4:    work_d = (work_q << s) | (work_q >> s_inv);
            default: work_d = work_q;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            out_q      <= '0;
            rem_q      <= '0;
            op_q       <= '0;
            err_q      <= 1'b0;
            flag_q     <= 1'b0;
            err_flag_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            flag_q     <= 1'b0;
            err_flag_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_IDLE;
                end
                S_RUN: begin
                    if (Shift_Clr) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        work_q <= work_d;
                        rem_q  <= rem_d[AW-1:0];
                        if (rem_d == '0) begin
                            out_q   <= work_d;
                            flag_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Illegal opcodes report here, one cycle after the start edge
                    flag_q     <= err_q;
                    err_flag_q <= err_q;
                    err_q      <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (start_ok) begin
                work_q  <= operand;
                op_q    <= ALU_FUN[2:0];
                rem_q   <= SHAMT;
                err_q   <= !legal;
                busy_q  <= legal;
                state_q <= legal ? S_RUN : S_DONE;
            end
        end
    end

    assign Shift_OUT  = out_q;
    assign Shift_Flag = flag_q;
    assign Shift_Err  = err_flag_q;
    assign Busy       = busy_q;

endmodule
